// File: rtl/nn_fxp_pkg.sv
// Shared fixed-point definitions for the neural-network inference blocks.
package nn_fxp_pkg;

  localparam int unsigned W_DEF    = 16;
  localparam int unsigned FRAC_DEF = 8;
  localparam int unsigned SR_W     = 64;

  // Most negative representable value; argmax seeds its running max with it.
  localparam logic signed [W_DEF-1:0] VERY_NEG = {1'b1, {(W_DEF-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_LAST,
    ST_WRITE,
    ST_DONE
  } fc_state_e;

  // Accumulator width that cannot overflow for n_in products of two w-bit values plus a bias.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned n_in);
    return 2 * w + $clog2(n_in) + 1;
  endfunction

  // Round half-up from Q.2FRAC down to Q.FRAC, then clamp to a signed w-bit range.
  function automatic logic signed [SR_W-1:0] sat_round(input logic signed [SR_W-1:0] acc,
                                                       input int unsigned w,
                                                       input int unsigned frac);
    logic signed [SR_W-1:0] r;
    logic signed [SR_W-1:0] hi;
    logic signed [SR_W-1:0] lo;
    r = acc;
    if (frac > 0) r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/fxp_mac.sv
// Registered signed multiply-accumulate with a bias-seeded first term.
module fxp_mac
  import nn_fxp_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned FRAC  = FRAC_DEF,
  parameter int unsigned N_IN  = 8,
  localparam int unsigned ACC_W = acc_width(W, N_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    en,
  input  logic signed [W-1:0]     x,
  input  logic signed [W-1:0]     w,
  input  logic signed [W-1:0]     b,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [W-1:0]     y_c
);

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_d;

  assign prod     = x * w;
  assign prod_ext = $signed({{(ACC_W-2*W){prod[2*W-1]}}, prod});
  assign bias_ext = $signed({{(ACC_W-W){b[W-1]}}, b}) <<< FRAC;

  // Value the accumulator takes if this cycle consumes a product.
  always_comb begin
    acc_d = acc;
    if (load) acc_d = bias_ext + prod_ext;
    else      acc_d = acc + prod_ext;
  end

  // Rounded/saturated view of the post-update sum, so the result can be captured
  // in the same edge that folds in the final product.
  assign y_c = W'(sat_round(SR_W'(acc_d), W, FRAC));

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst)     acc <= '0;
    else if (en) acc <= acc_d;
  end

endmodule

// File: rtl/dense_fc_layer.sv
// Fully connected layer: y[o] = sat(round(b[o] + sum_i w[o][i]*x[i])), written to Y RAM.
module dense_fc_layer
  import nn_fxp_pkg::*;
#(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned W     = W_DEF,
  parameter int unsigned FRAC  = FRAC_DEF,
  parameter int unsigned X_AW  = 3,
  parameter int unsigned WT_AW = 5,
  parameter int unsigned Y_AW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             x_cs,
  output logic [X_AW-1:0]  x_addr,
  input  logic [W-1:0]     x_dout,
  output logic             wt_cs,
  output logic [WT_AW-1:0] wt_addr,
  input  logic [W-1:0]     wt_dout,
  output logic             b_cs,
  output logic [Y_AW-1:0]  b_addr,
  input  logic [W-1:0]     b_dout,
  output logic             y_cs,
  output logic             y_we,
  output logic [Y_AW-1:0]  y_addr,
  output logic [W-1:0]     y_din
);

  localparam int unsigned I_W       = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned ACC_W     = acc_width(W, N_IN);
  localparam bit          SINGLE_IN = (N_IN == 1);

  fc_state_e        state, state_nx;
  logic [I_W-1:0]   i, i_nx;
  logic [Y_AW-1:0]  o, o_nx;

  logic             busy_nx, done_nx;
  logic             x_cs_nx, wt_cs_nx, b_cs_nx, y_cs_nx, y_we_nx;
  logic [X_AW-1:0]  x_addr_nx;
  logic [WT_AW-1:0] wt_addr_nx;
  logic [Y_AW-1:0]  b_addr_nx, y_addr_nx;
  logic [W-1:0]     y_din_nx;

  logic                    mac_en, mac_load;
  logic signed [W-1:0]     mac_y;
  logic signed [ACC_W-1:0] mac_acc_unused;

  fxp_mac #(
    .W    (W),
    .FRAC (FRAC),
    .N_IN (N_IN)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .load (mac_load),
    .en   (mac_en),
    .x    (x_dout),
    .w    (wt_dout),
    .b    (b_dout),
    .acc  (mac_acc_unused),
    .y_c  (mac_y)
  );

  // State and loop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      i     <= '0;
      o     <= '0;
    end else begin
      state <= state_nx;
      i     <= i_nx;
      o     <= o_nx;
    end
  end

  // Next state, counters, and next values of the registered memory-port outputs.
  always_comb begin
    state_nx = state;
    i_nx     = i;
    o_nx     = o;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_MAC;
          i_nx     = '0;
          o_nx     = '0;
        end
      end
      ST_MAC: begin
        if (i == I_W'(N_IN - 1)) state_nx = ST_LAST;
        else                     i_nx     = i + I_W'(1);
      end
      ST_LAST:  state_nx = ST_WRITE;
      ST_WRITE: begin
        if (o == Y_AW'(N_OUT - 1)) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_MAC;
          o_nx     = o + Y_AW'(1);
          i_nx     = '0;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase

    // Read data returned for i-1 is consumed in MAC (i>0) and in LAST.
    mac_en   = (state == ST_MAC && i != '0) || (state == ST_LAST);
    mac_load = (state == ST_MAC && i == I_W'(1)) || (state == ST_LAST && SINGLE_IN);

    // Outputs are registered, so they are derived from the state being entered.
    busy_nx    = (state_nx != ST_IDLE);
    done_nx    = (state_nx == ST_DONE);
    x_cs_nx    = (state_nx == ST_MAC);
    wt_cs_nx   = (state_nx == ST_MAC);
    b_cs_nx    = (state_nx == ST_MAC) && (i_nx == '0);
    y_cs_nx    = (state_nx == ST_WRITE);
    y_we_nx    = (state_nx == ST_WRITE);

    x_addr_nx  = x_cs_nx ? X_AW'(i_nx) : x_addr;
    b_addr_nx  = b_cs_nx ? o_nx : b_addr;
    y_addr_nx  = y_cs_nx ? o_nx : y_addr;
    y_din_nx   = y_cs_nx ? mac_y : y_din;

    // Weight address walks o*N_IN+i linearly across the whole run.
    wt_addr_nx = wt_addr;
    if (wt_cs_nx) wt_addr_nx = (state == ST_IDLE) ? '0 : wt_addr + WT_AW'(1);
  end

  // Registered control and memory-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      x_cs    <= 1'b0;
      wt_cs   <= 1'b0;
      b_cs    <= 1'b0;
      y_cs    <= 1'b0;
      y_we    <= 1'b0;
      x_addr  <= '0;
      wt_addr <= '0;
      b_addr  <= '0;
      y_addr  <= '0;
      y_din   <= '0;
    end else begin
      busy    <= busy_nx;
      done    <= done_nx;
      x_cs    <= x_cs_nx;
      wt_cs   <= wt_cs_nx;
      b_cs    <= b_cs_nx;
      y_cs    <= y_cs_nx;
      y_we    <= y_we_nx;
      x_addr  <= x_addr_nx;
      wt_addr <= wt_addr_nx;
      b_addr  <= b_addr_nx;
      y_addr  <= y_addr_nx;
      y_din   <= y_din_nx;
    end
  end

endmodule

// File: doc/dense_fc_layer.md
# dense_fc_layer

Fully connected inference layer that computes y[o] = sat(round(b[o] + Σ_i w[o][i]·x[i])) for every output neuron. It reads the input vector, weights and biases from single-port synchronous memories and writes each logit into Y RAM. It sits directly upstream of the argmax stage: its `done` pulse is wired to the argmax `start`, and its Y RAM write port shares the RAM that argmax reads.

## Interface

Parameters:

- `N_IN`, 8: input vector length.
- `N_OUT`, 4: output neurons. Must equal the argmax `N`.
- `W`, 16: signed data width for x, w, b and y.
- `FRAC`, 8: fractional bits; all data is signed Q(W-FRAC).FRAC.
- `X_AW`, 3: X RAM address width.
- `WT_AW`, 5: weight RAM address width. Must be ≥ clog2(N_IN·N_OUT).
- `Y_AW`, 2: Y RAM address width.

Ports:

- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle request; sampled only in IDLE.
- `busy`, out, 1: high from the cycle after start is accepted until the DONE cycle inclusive.
- `done`, out, 1: one-cycle pulse after the last Y write.
- `x_cs`, out, 1 / `x_addr`, out, X_AW / `x_dout`, in, W: X RAM read port.
- `wt_cs`, out, 1 / `wt_addr`, out, WT_AW / `wt_dout`, in, W: weight RAM read port; address = o·N_IN + i.
- `b_cs`, out, 1 / `b_addr`, out, Y_AW / `b_dout`, in, W: bias RAM read port; address = o.
- `y_cs`, out, 1 / `y_we`, out, 1 / `y_addr`, out, Y_AW / `y_din`, out, W: Y RAM write port.
- All RAMs use active-high CS and WE and have a registered read: data appears on `*_dout` one cycle after the CS cycle.

## Operation

- States are IDLE → MAC → LAST → WRITE, then back to MAC for the next o, or on to DONE → IDLE.
- **IDLE**: all CS and WE outputs are low. When `start`=1, clear o and i and go to MAC.
- **MAC** (N_IN cycles per neuron):
  - Issue the reads for x[i] and wt[o·N_IN+i].
  - On i=0, also issue the bias read b[o].
  - In each MAC cycle with i>0, consume the data returned for i-1.
  - i=N_IN-1 → LAST.
- **LAST**: no reads. Consume the product for i=N_IN-1.
- **Accumulate rule**:
  - On the first consume of a neuron: acc ← (sext(b) <<< FRAC) + x·w.
  - On every later consume: acc ← acc + x·w.
  - The product is a 2W-bit signed value in Q.2FRAC.
  - ACC_W = 2W + clog2(N_IN) + 1, which makes internal overflow impossible.
- **WRITE**: `y_cs`=1, `y_we`=1, `y_addr`=o, `y_din` = sat_W((acc + 2^(FRAC-1)) >>> FRAC).
  - Rounding is half-up.
  - Saturation clamps to [-2^(W-1), 2^(W-1)-1].
  - If o=N_OUT-1 → DONE; otherwise o++, i=0 → MAC.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- **Boundary conditions**:
  - `start` while busy: ignored, with no effect on sequencing.
  - `rst` at any point: next state IDLE, no further reads or writes, `done` not asserted.
  - An interrupted run leaves Y partially written, and this is legal.
  - `start` in the cycle right after DONE (IDLE) is accepted.
  - N_IN=1: MAC lasts one cycle, then LAST.

## Timing

- **Reset values**: `busy`=0, `done`=0, every `*_cs`=0, `y_we`=0, every address=0, `y_din`=0. Internal acc=0, o=0, i=0.
- **Per neuron**: N_IN+2 cycles (MAC×N_IN, LAST, WRITE).
- **Run timeline**, with start sampled at cycle 0:
  - First reads in cycle 1.
  - Write of neuron o in cycle (o+1)·(N_IN+2).
  - `done` in cycle N_OUT·(N_IN+2)+1.
  - With the defaults: 41.
- All outputs are registered.
- Y writes never overlap argmax activity, because argmax starts only after `done`.

## Structure

- **Package `nn_fxp_pkg`**:
  - Data width and FRAC defaults.
  - The state enum.
  - An ACC_W helper function.
  - A `sat_round` function. Argmax reuses the W and VERY_NEG constants from here.
- **Sub-module `fxp_mac`**:
  - Registered multiply-accumulate.
  - Inputs: `load` (bias-seeded first term), `en`, x, w, b.
  - Outputs acc, plus a combinational rounded/saturated y.
- The top level holds the FSM, counters and memory-port registers.

## Test plan

Use default parameters (Q8.8) for every scenario.

- **Basic**: all x=0x0100 (1.0), all w=0x0080 (0.5), b=0 → every y=0x0400. Expect four writes at cycles 10/20/30/40 and `done` at cycle 41.
- **Saturation**: all x=0x7F00, w=0x7F00 → y=0x7FFF. With w=0x8100 → y=0x8000.
- **Rounding**: x[0]=0x0001, w[0][0]=0x0080, all others 0, b=0 → y[0]=0x0001. With w[0][0]=0xFF80 → y[0]=0x0000.
- **Bias only**: x all 0, b[o]=0xFCC0 (-3.25) → y[o]=0xFCC0 for all o.
- **Control**:
  - A second `start` pulse at cycle 5 → ignored, timeline unchanged.
  - `rst` at cycle 15 → at most y[0] written, no `done`. A later `start` then completes in 41 cycles with correct y.
- **Chain with argmax**: weights giving y = {0x0100, 0xFF00, 0x0300, 0x0200} → argmax reports index 2 and maxval 0x0300 after `done`.
